// File: rtl/hbconsole_mux_pkg.sv
// Shared constants and encodings for the hexbus/console UART multiplexer.
package hbconsole_mux_pkg;

   localparam logic [6:0] HB_NEWLINE = 7'h0a;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_HBWORD = 1'b1
   } state_t;

   typedef enum logic {
      SRC_HB      = 1'b0,
      SRC_CONSOLE = 1'b1
   } src_t;

endpackage

// File: rtl/hbconsole_arb.sv
// Transmit arbiter: keeps hexbus words atomic, alternates on ties, and
// releases a stalled hexbus word after 2^LGTIMEOUT-1 idle cycles.
module hbconsole_arb
   import hbconsole_mux_pkg::*;
#(
   parameter int LGTIMEOUT = 10
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_load,
   input  logic       i_hb_stb,
   input  logic [6:0] i_hb_data,
   input  logic       i_console_stb,
   output logic       o_grant_hb,
   output logic       o_grant_con
);

   // Compare against max-1: the cycle that would make the count reach max releases the word.
   localparam logic [LGTIMEOUT-1:0] TIMEOUT_ARM = {{(LGTIMEOUT-1){1'b1}}, 1'b0};

   state_t               state, state_next;
   src_t                 last_served, last_next;
   logic [LGTIMEOUT-1:0] idle_cnt, idle_next;
   logic                 hb_xfer, con_xfer;

   assign hb_xfer  = i_hb_stb && i_load && o_grant_hb;
   assign con_xfer = i_console_stb && i_load && o_grant_con;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= ST_IDLE;
         idle_cnt    <= '0;
         last_served <= SRC_CONSOLE;
      end else begin
         state       <= state_next;
         idle_cnt    <= idle_next;
         last_served <= last_next;
      end
   end

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      state_next = state;
      idle_next  = idle_cnt;
      last_next  = last_served;

      if (hb_xfer)
         last_next = SRC_HB;
      else if (con_xfer)
         last_next = SRC_CONSOLE;

      case (state)
         ST_IDLE: begin
            idle_next = '0;
            if (hb_xfer && (i_hb_data != HB_NEWLINE))
               state_next = ST_HBWORD;
         end
         ST_HBWORD: begin
            if (hb_xfer) begin
               idle_next = '0;
               if (i_hb_data == HB_NEWLINE)
                  state_next = ST_IDLE;
            end else if (!i_hb_stb) begin
               if (idle_cnt == TIMEOUT_ARM) begin
                  state_next = ST_IDLE;
                  idle_next  = '0;
               end else begin
                  idle_next = idle_cnt + 1'b1;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      o_grant_hb  = 1'b0;
      o_grant_con = 1'b0;
      case (state)
         ST_IDLE: begin
            if (i_hb_stb && i_console_stb) begin
               o_grant_hb  = (last_served == SRC_CONSOLE);
               o_grant_con = (last_served == SRC_HB);
            end else begin
               o_grant_hb  = i_hb_stb;
               o_grant_con = i_console_stb;
            end
         end
         ST_HBWORD: o_grant_hb = i_hb_stb;
         default: ;
      endcase
   end

endmodule

// File: rtl/hbconsole_mux.sv
// Shares one UART byte stream between the console and the hexbus channel;
// bit 7 tags the source on transmit and selects the destination on receive.
module hbconsole_mux
   import hbconsole_mux_pkg::*;
#(
   parameter int   LGTIMEOUT   = 10,
   parameter logic CONSOLE_TAG = 1'b1
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_rx_stb,
   input  logic [7:0] i_rx_data,
   output logic       o_hb_stb,
   output logic [6:0] o_hb_data,
   output logic       o_console_stb,
   output logic [6:0] o_console_data,
   input  logic       i_hb_stb,
   input  logic [6:0] i_hb_data,
   output logic       o_hb_busy,
   input  logic       i_console_stb,
   input  logic [6:0] i_console_data,
   output logic       o_console_busy,
   output logic       o_tx_stb,
   output logic [7:0] o_tx_data,
   input  logic       i_tx_busy
);

   logic load, grant_hb, grant_con, hb_xfer, con_xfer;
   logic rx_is_console;

   // The output register can take a byte when empty or when its current byte leaves this cycle.
   assign load           = !o_tx_stb || !i_tx_busy;
   assign o_hb_busy      = !(load && grant_hb);
   assign o_console_busy = !(load && grant_con);
   assign hb_xfer        = i_hb_stb && !o_hb_busy;
   assign con_xfer       = i_console_stb && !o_console_busy;

   hbconsole_arb #(
      .LGTIMEOUT(LGTIMEOUT)
   ) u_arb (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_load       (load),
      .i_hb_stb     (i_hb_stb),
      .i_hb_data    (i_hb_data),
      .i_console_stb(i_console_stb),
      .o_grant_hb   (grant_hb),
      .o_grant_con  (grant_con)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_tx_stb  <= 1'b0;
         o_tx_data <= '0;
      end else if (hb_xfer) begin
         o_tx_stb  <= 1'b1;
         o_tx_data <= {~CONSOLE_TAG, i_hb_data};
      end else if (con_xfer) begin
         o_tx_stb  <= 1'b1;
         o_tx_data <= {CONSOLE_TAG, i_console_data};
      end else if (!i_tx_busy) begin
         o_tx_stb  <= 1'b0;
      end
   end

   assign rx_is_console = (i_rx_data[7] == CONSOLE_TAG);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_console_stb  <= 1'b0;
         o_console_data <= '0;
         o_hb_stb       <= 1'b0;
         o_hb_data      <= '0;
      end else begin
         o_console_stb <= i_rx_stb && rx_is_console;
         o_hb_stb      <= i_rx_stb && !rx_is_console;
         if (i_rx_stb && rx_is_console)
            o_console_data <= i_rx_data[6:0];
         if (i_rx_stb && !rx_is_console)
            o_hb_data <= i_rx_data[6:0];
      end
   end

endmodule

// File: doc/hbconsole_mux.md
Name: hbconsole_mux

Overview:
- Sits between the console peripheral and the single UART byte stream it shares with the hexbus debug channel.
- Transmit path: merges 7-bit console characters and 7-bit hexbus characters onto one 8-bit UART transmit stream. Bit 7 tags the source.
- Receive path: splits incoming UART bytes by bit 7. Console bytes go to the console receiver; the rest go to the hexbus decoder.
- Keeps hexbus words atomic: console characters are never inserted mid-word.

Parameters:
- LGTIMEOUT, 10: log2 of the idle-cycle limit before a stalled hexbus word lock is forcibly released.
- CONSOLE_TAG, 1'b1: value of bit 7 that marks a console byte. Hexbus bytes carry the inverse.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_rx_stb  in  1  UART receive byte valid (single cycle)
- i_rx_data  in  8  UART receive byte
- o_hb_stb  out  1  byte valid to hexbus decoder
- o_hb_data  out  7  byte to hexbus decoder
- o_console_stb  out  1  byte valid to console receiver
- o_console_data  out  7  byte to console receiver
- i_hb_stb  in  1  hexbus transmit request
- i_hb_data  in  7  hexbus transmit character
- o_hb_busy  out  1  hexbus transmit not accepted this cycle
- i_console_stb  in  1  console transmit request
- i_console_data  in  7  console transmit character
- o_console_busy  out  1  console transmit not accepted this cycle
- o_tx_stb  out  1  byte valid to UART transmitter
- o_tx_data  out  8  byte to UART transmitter
- i_tx_busy  in  1  UART transmitter busy

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: all stb outputs 0; o_tx_data, o_hb_data and o_console_data 0; state IDLE; timeout counter 0; last_served = CONSOLE.

Handshakes:
- Source side uses stb/busy. A source holds stb and data stable while busy is high. Transfer occurs on a cycle with stb && !busy.
- load = !o_tx_stb || !i_tx_busy (output register free or draining this cycle).
- o_hb_busy = !(load && grant_hb). o_console_busy = !(load && grant_con). Both are combinational.
- On transfer, o_tx_stb <= 1 next cycle. o_tx_data <= {CONSOLE_TAG, i_console_data} or {~CONSOLE_TAG, i_hb_data}.
- o_tx_stb clears on a cycle with !i_tx_busy and no new transfer. It holds through i_tx_busy.
- Back-to-back transfers are possible at one per cycle while i_tx_busy is low.

Arbiter FSM, states IDLE and HBWORD:
- IDLE, one requester: grant that requester.
- IDLE, both requesting: grant the source not equal to last_served. last_served updates on every transfer.
- IDLE: a hexbus transfer whose character is not 7'h0a moves to HBWORD. A hexbus 7'h0a stays in IDLE.
- HBWORD: grant_con = 0; grant_hb = i_hb_stb.
- HBWORD: a hexbus transfer of 7'h0a returns to IDLE.
- Timeout counter: increments each HBWORD cycle without i_hb_stb and clears on any hexbus transfer.
- Timeout release: when the counter reaches 2^LGTIMEOUT-1, next state is IDLE and the counter clears. A hexbus stb held but blocked by i_tx_busy does not count as idle.
- Console requests are held, never dropped. Latency from stb to o_tx_stb is 1 cycle when load is true.

Receive demux:
- 1-cycle registered latency. No backpressure exists.
- When i_rx_stb is high and i_rx_data[7]==CONSOLE_TAG: next cycle o_console_stb=1 and o_console_data=i_rx_data[6:0].
- When i_rx_stb is high with the other tag: the same, on o_hb_stb/o_hb_data.
- Strobes are single-cycle. Data registers hold their last value.
- Receive and transmit paths are independent; simultaneous activity is allowed.
- Reset mid-operation: a pending o_tx_stb is dropped and the byte is lost. A console or hexbus source still asserting stb after reset is re-arbitrated from IDLE.

Decomposition:
- Shared package constants:
  - HB_NEWLINE = 7'h0a
  - state encoding (IDLE=1'b0, HBWORD=1'b1)
  - source encoding for last_served (HB=1'b0, CONSOLE=1'b1)
- One sub-module, hbconsole_arb: the FSM, timeout counter, last_served and grant logic. The top level holds the output register and the receive demux.

Test Plan:
- RX split: i_rx_stb with 8'hc1, then 8'h35 -> o_console_stb with 7'h41 one cycle later; next cycle o_hb_stb with 7'h35; never both strobes on the same byte.
- Word atomicity: hexbus sends 'A','1','2' while console holds 'x' -> o_tx_data sequence 8'h41,8'h31,8'h32. Then hexbus sends 7'h0a -> 8'h0a. Then 8'hf8 ('x' tagged). o_console_busy stays high until the newline transfers.
- Tie fairness in IDLE: both stb continuously, hexbus sending only 7'h0a, console 'a' -> output alternates 8'h0a, 8'he1, 8'h0a, ... with hexbus first after reset.
- Backpressure: i_tx_busy high for 20 cycles with o_tx_stb=1 -> o_tx_data stable, both source busys high; on release the held request transfers in the same cycle.
- Timeout: LGTIMEOUT=4, hexbus sends 'A' then idles, console requests -> console served exactly at the 15th idle cycle plus 1 and not earlier.
- Reset mid-transfer: i_rst during o_tx_stb=1 with i_tx_busy=1 -> next cycle o_tx_stb=0 and state IDLE; a following tie grants hexbus.
